// File: rtl/seg_pkg.sv
// Shared constants and helpers for the seven-segment scan controller.
//   NDIG      : number of display digits
//   DIG_W     : width of a digit index
//   AN_OFF    : anode pattern with every digit dark (active-low)
//   DIG_FIRST : digit scanned first in each frame (leftmost)
//   an_of()   : digit index -> one-hot-low anode pattern
package seg_pkg;

   localparam int unsigned NDIG  = 4;
   localparam int unsigned DIG_W = 2;
   localparam int unsigned NIB_W = 4;
   localparam int unsigned VAL_W = NDIG * NIB_W;

   localparam logic [NDIG-1:0]  AN_OFF    = 4'b1111;
   localparam logic [DIG_W-1:0] DIG_FIRST = 2'd3;

   // Active-low anode pattern selecting a single digit.
   function automatic logic [NDIG-1:0] an_of(input logic [DIG_W-1:0] dig);
      an_of = ~(NDIG'(1) << dig);
   endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Dwell counter and digit sequencer for the scan controller.
//   clk, rst_n      : clock, async active-low reset
//   o_cnt           : dwell counter, one digit is shown for 2^SCAN_W cycles
//   o_dig           : digit currently selected, scans 3 -> 2 -> 1 -> 0 -> 3
//   o_frame_end_c   : last cycle of the frame (digit 0, counter all-ones)
module seg_scan_timer
   import seg_pkg::*;
#(
   parameter int unsigned SCAN_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [SCAN_W-1:0] o_cnt,
   output logic [DIG_W-1:0]  o_dig,
   output logic              o_frame_end_c
);

   logic [SCAN_W-1:0] r_cnt;
   logic [DIG_W-1:0]  r_dig;

   // Counter wraps naturally; the digit steps down and wraps 0 -> 3, which
   // also realigns the frame at the boundary without extra logic.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_dig <= DIG_FIRST;
      end else begin
         r_cnt <= r_cnt + SCAN_W'(1);
         if (&r_cnt) begin
            r_dig <= r_dig - DIG_W'(1);
         end
      end
   end

   assign o_cnt         = r_cnt;
   assign o_dig         = r_dig;
   assign o_frame_end_c = (&r_cnt) && (r_dig == '0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller with double-buffered display
// value, per-frame PWM brightness and leading-zero blanking.
//   clk, rst_n  : clock, async active-low reset
//   wr_valid    : write request for a new 16-bit display value
//   wr_ready    : pending buffer empty (combinational from its flag)
//   wr_data     : four nibbles, [15:12] is digit 3 (leftmost)
//   bright      : brightness, sampled at frame boundaries
//   lz_blank    : leading-zero blanking enable, sampled at frame boundaries
//   an          : active-low anodes, an[3] is digit 3
//   bcd         : nibble of the currently selected digit
//   frame_tick  : one-cycle pulse at the start of each frame
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int unsigned SCAN_W   = 16,
   parameter int unsigned BRIGHT_W = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wr_valid,
   output logic                wr_ready,
   input  logic [VAL_W-1:0]    wr_data,
   input  logic [BRIGHT_W-1:0] bright,
   input  logic                lz_blank,
   output logic [NDIG-1:0]     an,
   output logic [NIB_W-1:0]    bcd,
   output logic                frame_tick
);

   logic [SCAN_W-1:0]   w_cnt;
   logic [DIG_W-1:0]    w_dig;
   logic                w_frame_end;
   logic                w_accept;
   logic                w_pwm_on;
   logic                w_blank;
   logic                w_lit;
   logic [3:0]          w_shift;
   logic [NIB_W-1:0]    w_nib;

   logic [VAL_W-1:0]    r_pend;
   logic                r_pend_full;
   logic [VAL_W-1:0]    r_act;
   logic [BRIGHT_W-1:0] r_bright_act;
   logic                r_lz_act;

   seg_scan_timer #(
      .SCAN_W (SCAN_W)
   ) u_timer (
      .clk           (clk),
      .rst_n         (rst_n),
      .o_cnt         (w_cnt),
      .o_dig         (w_dig),
      .o_frame_end_c (w_frame_end)
   );

   assign wr_ready = ~r_pend_full;
   assign w_accept = wr_valid & ~r_pend_full;

   // Comparing the full counter against the level scaled to the top of the
   // dwell is equivalent to comparing the top BRIGHT_W bits against it.
   assign w_pwm_on = w_cnt < (SCAN_W'(r_bright_act) << (SCAN_W - BRIGHT_W));

   // A digit above 0 is blanked when it and every higher nibble are zero.
   assign w_shift  = {w_dig, 2'b00};
   assign w_blank  = r_lz_act && (w_dig != '0) && ((r_act >> w_shift) == '0);
   assign w_lit    = w_pwm_on && !w_blank;
   assign w_nib    = r_act[w_shift +: NIB_W];

   // Buffering, frame-boundary latching and the registered display outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend       <= '0;
         r_pend_full  <= 1'b0;
         r_act        <= '0;
         r_bright_act <= '0;
         r_lz_act     <= 1'b0;
         an           <= AN_OFF;
         bcd          <= '0;
         frame_tick   <= 1'b0;
      end else begin
         frame_tick <= w_frame_end;
         an         <= w_lit ? an_of(w_dig) : AN_OFF;
         bcd        <= w_nib;
         if (w_frame_end) begin
            r_bright_act <= bright;
            r_lz_act     <= lz_blank;
            if (r_pend_full) begin
               r_act       <= r_pend;
               r_pend_full <= 1'b0;
            end
         end
         // Only possible while empty, so it never collides with the move above.
         if (w_accept) begin
            r_pend      <= wr_data;
            r_pend_full <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with a 64-cycle dwell / 256-cycle frame.
module tb_seg_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_valid;
   logic        wr_ready;
   logic [15:0] wr_data;
   logic [1:0]  bright;
   logic        lz_blank;
   logic [3:0]  an;
   logic [3:0]  bcd;
   logic        frame_tick;

   int checks = 0;
   int errors = 0;

   // Reference model state: time since reset release plus the buffer contents.
   int          t;
   logic [15:0] m_pend;
   logic        m_full;
   logic [15:0] m_act;
   int          m_bright;
   logic        m_lz;
   logic        last_acc;

   always #5 clk = ~clk;

   seg_scan_ctrl #(
      .SCAN_W   (6),
      .BRIGHT_W (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_data    (wr_data),
      .bright     (bright),
      .lz_blank   (lz_blank),
      .an         (an),
      .bcd        (bcd),
      .frame_tick (frame_tick)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h (t=%0d)", tag, obs, exp, t);
      end
   endtask

   task automatic model_reset();
      t = 0; m_pend = '0; m_full = 0; m_act = '0; m_bright = 0; m_lz = 0;
   endtask

   // One clock: called just after a negedge with inputs already driven.
   task automatic step();
      int          c, d;
      logic        bnd, lit, acc;
      logic [3:0]  exp_an, exp_bcd;
      chk("wr_ready", {15'd0, wr_ready}, {15'd0, !m_full});
      c   = t % 64;
      d   = 3 - ((t / 64) % 4);
      bnd = (t % 256) == 255;
      lit = ((c / 16) < m_bright) && !(m_lz && d != 0 && (m_act >> (4 * d)) == 16'h0);
      exp_an  = lit ? ~(4'b0001 << d) : 4'b1111;
      exp_bcd = m_act[4 * d +: 4];
      acc = wr_valid && !m_full;
      @(posedge clk);
      if (bnd) begin
         m_bright = int'(bright);
         m_lz     = lz_blank;
         if (m_full) begin
            m_act  = m_pend;
            m_full = 0;
         end
      end
      if (acc) begin
         m_pend = wr_data;
         m_full = 1;
      end
      t++;
      last_acc = acc;
      #1;
      chk("an", {12'd0, an}, {12'd0, exp_an});
      chk("bcd", {12'd0, bcd}, {12'd0, exp_bcd});
      chk("frame_tick", {15'd0, frame_tick}, {15'd0, bnd});
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic write(input logic [15:0] data);
      bit done = 0;
      wr_valid = 1'b1;
      wr_data  = data;
      for (int i = 0; i < 600 && !done; i++) begin
         step();
         done = last_acc;
      end
      wr_valid = 1'b0;
      if (!done) begin
         checks++; errors++;
         $error("FAIL write_timeout: observed no accept expected accept of %h", data);
      end
   endtask

   task automatic wait_tick();
      bit seen = 0;
      for (int i = 0; i < 300 && !seen; i++) begin
         step();
         seen = (frame_tick === 1'b1);
      end
      if (!seen) begin
         checks++; errors++;
         $error("FAIL tick_timeout: observed no frame_tick expected one within 300 cycles");
      end
   endtask

   // Counts lit cycles over the frame following an observed frame_tick;
   // optionally drops brightness to 1 after chg_at cycles.
   task automatic count_frame(input string tag, input int chg_at, input int exp_lit);
      int n = 0;
      for (int i = 0; i < 256; i++) begin
         if (i == chg_at) bright = 2'd1;
         step();
         if (an !== 4'b1111) n++;
      end
      chk(tag, 16'(n), 16'(exp_lit));
   endtask

   initial begin
      rst_n = 1'b0; wr_valid = 1'b0; wr_data = '0; bright = 2'd3; lz_blank = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_an", {12'd0, an}, 16'h000F);
      chk("rst_bcd", {12'd0, bcd}, 16'h0000);
      chk("rst_tick", {15'd0, frame_tick}, 16'h0000);
      chk("rst_ready", {15'd0, wr_ready}, 16'h0001);
      @(negedge clk);
      rst_n = 1'b1;

      // First frame dark, first tick 256 cycles after release.
      run(256);

      // Basic display, 48 of 64 cycles lit per digit.
      write(16'h1234);
      wait_tick();
      wait_tick();
      count_frame("lit_1234", -1, 192);

      // Back-to-back writes: second stalls until the boundary.
      write(16'hAAAA);
      write(16'hBBBB);
      run(600);

      // Leading-zero blanking.
      lz_blank = 1'b1;
      write(16'h0050);
      run(600);
      write(16'h0000);
      run(600);

      // Mid-frame brightness change applies from the next frame only.
      lz_blank = 1'b0;
      write(16'h1234);
      wait_tick();
      wait_tick();
      count_frame("lit_keep", 100, 192);
      count_frame("lit_dim", -1, 64);
      bright = 2'd3;

      // Randomized traffic against the model.
      for (int i = 0; i < 2000; i++) begin
         wr_valid = ($urandom_range(0, 7) == 0);
         wr_data  = 16'($urandom);
         if ($urandom_range(0, 99) == 0) bright = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 149) == 0) lz_blank = 1'($urandom_range(0, 1));
         step();
      end
      wr_valid = 1'b0;

      // Async reset with a pending value that must be discarded.
      bright = 2'd3; lz_blank = 1'b0;
      wait_tick();
      run(300);
      write(16'h9876);
      run(40);
      chk("pend_full_before_rst", {15'd0, wr_ready}, 16'h0000);
      #2 rst_n = 1'b0;
      #1;
      chk("async_an", {12'd0, an}, 16'h000F);
      chk("async_bcd", {12'd0, bcd}, 16'h0000);
      chk("async_ready", {15'd0, wr_ready}, 16'h0001);
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run(900);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Scan controller for the 4-digit seven-segment display on the board.
- Owns digit sequencing, anode drive, per-frame PWM brightness and leading-zero blanking.
- Takes new 16-bit display values through a valid/ready write port and double-buffers them so that updates apply only on frame boundaries, which prevents tearing.
- Its bcd output feeds the existing BCD-to-segment decoder. Its an output drives the board anodes directly.

Parameters:
- SCAN_W, 16, width of the dwell counter; each digit is on screen for 2^SCAN_W clk cycles.
- BRIGHT_W, 4, brightness resolution; the dwell is split into 2^BRIGHT_W PWM slots. Must be at most SCAN_W.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous assert, active-low
- wr_valid  in  1  write request for new display value
- wr_ready  out  1  pending buffer empty; write accepted when wr_valid & wr_ready
- wr_data  in  16  four nibbles; [15:12] is the leftmost digit (3), [3:0] the rightmost (0)
- bright  in  BRIGHT_W  brightness level; 0 = dark, max = (2^BRIGHT_W - 1)/2^BRIGHT_W duty
- lz_blank  in  1  enable leading-zero blanking
- an  out  4  anodes, active-low, one-hot-low when lit; an[3] is digit 3
- bcd  out  4  nibble of the digit currently selected
- frame_tick  out  1  one-cycle pulse when a new frame starts

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low, named rst_n. All state is cleared when rst_n = 0, independent of clk.
- State: cnt[SCAN_W-1:0], dig[1:0], pend[15:0], pend_full, act[15:0], bright_act, lz_act.
- Reset values:
  - cnt = 0, dig = 3, pend_full = 0, act = 16'h0000, bright_act = 0, lz_act = 0.
  - Outputs: an = 4'b1111, bcd = 4'h0, frame_tick = 0, wr_ready = 1 once out of reset.
- Scan:
  - cnt increments every cycle and wraps to 0.
  - When cnt is all-ones, dig advances in the order 3 -> 2 -> 1 -> 0 -> 3.
  - Frame boundary = the cycle with dig == 0 and cnt all-ones.
- Write port:
  - wr_ready = ~pend_full, driven combinationally from the register.
  - On an accepted write: pend <= wr_data, pend_full <= 1.
  - While pend_full = 1, wr_data is ignored and pend is not overwritten.
- Frame-boundary edge actions, all on the same edge:
  - cnt -> 0, dig -> 3.
  - bright_act <= bright, lz_act <= lz_blank.
  - If pend_full: act <= pend and pend_full <= 0.
  - frame_tick <= 1 for exactly one cycle.
- Simultaneous write at the boundary:
  - If pend_full was 1, the pend contents move to act. The new write is not accepted because wr_ready = 0 that cycle.
  - If pend_full was 0, the write lands in pend and is applied at the next boundary. It never goes straight to act.
- Lit condition, evaluated per cycle. A digit is lit only if both hold:
  - PWM: cnt[SCAN_W-1 -: BRIGHT_W] < bright_act.
  - Not LZ-blanked: with lz_act = 1, digit d (for d = 3..1) is blanked when its nibble and every higher nibble of act are 0. Digit 0 is never blanked.
- Outputs are registered; an/bcd change one cycle after the corresponding cnt/dig state.
  - When lit: an = ~(4'b0001 << dig).
  - When not lit: an = 4'b1111.
  - bcd = act nibble of dig, always, lit or not.
- Mid-operation changes to bright or lz_blank have no effect until the next frame boundary.
- Reset asserted mid-frame: pend is discarded, act returns to 0, and the display goes dark (bright_act = 0) until the first boundary after release.

Decomposition:
- Package seg_pkg:
  - NDIG = 4
  - AN_OFF = 4'b1111
  - DIG_FIRST = 2'd3
  - Function mapping a digit index to an active-low anode pattern.
- One sub-module, seg_scan_timer:
  - Contains cnt, dig and frame-boundary generation.
  - Outputs cnt, dig, frame_end.
- Buffering, blanking and the output registers stay in seg_scan_ctrl.

Test Plan (SCAN_W=6, BRIGHT_W=2: 64-cycle dwell, 256-cycle frame):
- Reset, then hold rst_n = 1 with no writes -> an = 4'b1111 for the whole first frame; first frame_tick 256 cycles after release; wr_ready = 1.
- Write 16'h1234 with bright = 3, lz_blank = 0 -> after the next frame_tick, each dwell shows an = 0111/1011/1101/1110 with bcd = 1/2/3/4, lit 48 of 64 cycles per digit; frame_tick period is 256.
- Two back-to-back writes, 16'hAAAA then 16'hBBBB -> first accepted and wr_ready drops; second stalls until the boundary; display shows AAAA for one frame, then BBBB.
- Write 16'h0050 with lz_blank = 1, bright = 3 -> digits 3 and 2 dark all frame; digits 1 and 0 lit with bcd = 5 and 0. Write 16'h0000 -> only digit 0 lit, with bcd = 0.
- Change bright 3 -> 1 mid-frame -> current frame keeps the 48-cycle lit time; the next frame is lit 16 cycles per dwell.
- Assert rst_n = 0 mid-frame with pend_full = 1 -> an = 4'b1111 immediately, without waiting for clk; after release wr_ready = 1, act = 0, and the discarded pending value is never displayed.
